// File: rtl/data_rx_param_rgb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_rx_param_rgb                                            |
// | Description : AL422 pixel receiver. Compares one intensity byte per clock  |
// |               against the PWM threshold through a 3-stage compare pipeline.|
// |               Packs the results into N_ROWS x CH colour bits. Generates    |
// |               LED shift-clock, PWM-counter and AL422-reset strobes.        |
// |               Supports stall, phase resync and an aligned (shadowed)       |
// |               output mode.                                                 |
// | Revision    : 1.0 - initial parametrised release                           |
// +----------------------------------------------------------------------------+
module data_rx_param_rgb #(
  parameter int DW          = 8,
  parameter int N_ROWS      = 2,
  parameter int CH          = 3,
  parameter int ALRST_PHASE = N_ROWS*CH-2,
  parameter int ALIGN_OUT   = 1
) (
  input  logic                   in_clk,
  input  logic                   in_nrst,
  input  logic                   in_en,
  input  logic                   in_sync,
  input  logic [DW-1:0]          in_data,
  input  logic [DW-1:0]          pwm_value,
  output logic                   led_clk,
  output logic                   pwm_cntr_strobe,
  output logic                   alrst_strobe,
  output logic                   out_load,
  output logic [N_ROWS*CH-1:0]   rgb_out
);

  localparam int PHASES = N_ROWS*CH;
  localparam int PW     = (PHASES > 1) ? $clog2(PHASES) : 1;
  // One extra code is reserved so that a tag can mean "no valid phase".
  localparam int TW     = $clog2(PHASES+1);
  localparam int HW     = DW/2;

  localparam logic [TW-1:0] TAG_NONE   = TW'(PHASES);
  localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES-1);
  localparam logic [PW-1:0] ALRST_PH   = PW'(ALRST_PHASE);

  logic [PW-1:0]     phase_cntr;
  logic [PW-1:0]     eff_phase;

  logic [DW-1:0]     d1;
  logic [DW-1:0]     p1;
  logic [TW-1:0]     tag1;
  logic              hi_gt2;
  logic              hi_eq2;
  logic              lo_gt2;
  logic [TW-1:0]     tag2;
  logic              cmp3;
  logic [TW-1:0]     tag3;

  logic [CH-1:0]     row_bits;
  logic [N_ROWS-1:0] row_done;

  // A sync pulse overrides the counter so the current byte is treated as phase 0.
  assign eff_phase = in_sync ? '0 : phase_cntr;

  assign pwm_cntr_strobe = in_nrst & in_en & (eff_phase == '0);
  assign alrst_strobe    = in_nrst & in_en & (eff_phase == ALRST_PH);
  assign led_clk         = in_nrst & in_en & (eff_phase == LAST_PHASE);

  // Phase counter: advances from the effective phase, wrapping after the last phase.
  always_ff @(posedge in_clk) begin
    if (!in_nrst) begin
      phase_cntr <= '0;
    end else if (in_en) begin
      phase_cntr <= (eff_phase == LAST_PHASE) ? '0 : eff_phase + PW'(1);
    end
  end

  // S1: capture byte, threshold and the phase it belongs to.
  always_ff @(posedge in_clk) begin
    if (!in_nrst) begin
      d1   <= '0;
      p1   <= '0;
      tag1 <= TAG_NONE;
    end else if (in_en) begin
      d1   <= in_data;
      p1   <= pwm_value;
      tag1 <= TW'(eff_phase);
    end
  end

  // S2: split the magnitude compare into half-width pieces.
  always_ff @(posedge in_clk) begin
    if (!in_nrst) begin
      hi_gt2 <= 1'b0;
      hi_eq2 <= 1'b0;
      lo_gt2 <= 1'b0;
      tag2   <= TAG_NONE;
    end else if (in_en) begin
      hi_gt2 <= d1[DW-1:HW] >  p1[DW-1:HW];
      hi_eq2 <= d1[DW-1:HW] == p1[DW-1:HW];
      lo_gt2 <= d1[HW-1:0]  >  p1[HW-1:0];
      tag2   <= tag1;
    end
  end

  // S3: combine the halves into an exact unsigned data > threshold result.
  always_ff @(posedge in_clk) begin
    if (!in_nrst) begin
      cmp3 <= 1'b0;
      tag3 <= TAG_NONE;
    end else if (in_en) begin
      cmp3 <= hi_gt2 | (hi_eq2 & lo_gt2);
      tag3 <= tag2;
    end
  end

  // S4: row assembly. The shift register only keeps the CH-1 earlier bits;
  // the newest bit comes straight from S3 so a completed row is available
  // on the same edge that its last channel arrives.
  generate
    if (CH == 1) begin : g_ch_single
      assign row_bits = cmp3;
    end else begin : g_ch_multi
      logic [CH-2:0] shift_q;

      assign row_bits = {shift_q, cmp3};

      // Shift each compare result in, first byte ending up in the MSB.
      always_ff @(posedge in_clk) begin
        if (!in_nrst) begin
          shift_q <= '0;
        end else if (in_en) begin
          shift_q <= row_bits[CH-2:0];
        end
      end
    end
  endgenerate

  // Row r is complete when its last channel's tag reaches S4.
  always_comb begin
    row_done = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      row_done[r] = (tag3 == TW'(r*CH + CH - 1));
    end
  end

  generate
    if (ALIGN_OUT != 0) begin : g_align
      logic [N_ROWS*CH-1:0] rgb_q;
      logic                 load_q;
      logic [N_ROWS*CH-1:0] aligned_next;

      if (N_ROWS > 1) begin : g_shadow
        logic [(N_ROWS-1)*CH-1:0] shadow_q;

        assign aligned_next = {row_bits, shadow_q};

        // Park completed rows until the final row of the group arrives.
        always_ff @(posedge in_clk) begin
          if (!in_nrst) begin
            shadow_q <= '0;
          end else if (in_en) begin
            for (int r = 0; r < N_ROWS-1; r++) begin
              if (row_done[r]) begin
                shadow_q[r*CH +: CH] <= row_bits;
              end
            end
          end
        end
      end else begin : g_no_shadow
        assign aligned_next = row_bits;
      end

      // Publish all rows together and flag the update for one cycle.
      always_ff @(posedge in_clk) begin
        if (!in_nrst) begin
          rgb_q  <= '0;
          load_q <= 1'b0;
        end else begin
          load_q <= 1'b0;
          if (in_en && row_done[N_ROWS-1]) begin
            rgb_q  <= aligned_next;
            load_q <= 1'b1;
          end
        end
      end

      assign rgb_out  = rgb_q;
      assign out_load = load_q;
    end else begin : g_legacy
      logic [N_ROWS*CH-1:0] rgb_q;

      // Each row goes to the output as soon as it is complete.
      always_ff @(posedge in_clk) begin
        if (!in_nrst) begin
          rgb_q <= '0;
        end else if (in_en) begin
          for (int r = 0; r < N_ROWS; r++) begin
            if (row_done[r]) begin
              rgb_q[r*CH +: CH] <= row_bits;
            end
          end
        end
      end

      assign rgb_out  = rgb_q;
      assign out_load = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire
